// File: rtl/bbox_scan_ctrl_pkg.sv
// Shared types for the bounding-box scan controller: ray/box vectors, the
// no-hit distance and the scan state encoding.
package bbox_scan_ctrl_pkg;

    typedef struct packed {
        logic signed [15:0] x;
        logic signed [15:0] y;
        logic signed [15:0] z;
    } vec3;

    typedef struct packed {
        logic signed [35:0] x;
        logic signed [35:0] y;
        logic signed [35:0] z;
    } vec3_18_18;

    typedef struct packed {
        vec3 lo;
        vec3 hi;
    } bbox;

    localparam vec3 vec3_default = '{x: 16'sd0, y: 16'sd0, z: 16'sd0};

    localparam int DIST_W = 49;
    localparam logic [DIST_W-1:0] NO_HIT_DIST = {DIST_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } scan_state_e;

    // Strictly closer wins, so on a distance tie the earlier index is kept.
    function automatic logic closer_hit(input logic have_hit,
                                        input logic [DIST_W-1:0] cand,
                                        input logic [DIST_W-1:0] best);
        return !have_hit || (cand < best);
    endfunction

endpackage

// File: rtl/stall_shift_reg.sv
// Fixed-depth delay line that advances one stage per unstalled cycle.
module stall_shift_reg #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 5
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_stall,
    input  logic [WIDTH-1:0] i_din,
    output logic [WIDTH-1:0] o_dout
);

    logic [WIDTH-1:0] r_stage [DEPTH];

    // Shift the line on unstalled cycles; reset empties every stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_stage[i] <= {WIDTH{1'b0}};
            end
        end else if (!i_stall) begin
            r_stage[0] <= i_din;
            for (int i = 1; i < DEPTH; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign o_dout = r_stage[DEPTH-1];

endmodule

// File: rtl/bbox_scan_ctrl.sv
// Streams boxes for one ray through an external intersection datapath and
// reports the closest hit (lowest index on ties).
module bbox_scan_ctrl
    import bbox_scan_ctrl_pkg::*;
#(
    parameter int IDX_W  = 8,
    parameter int DP_LAT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_ray_valid,
    output logic              o_ray_ready,
    input  vec3               i_ray_orig,
    input  vec3_18_18         i_inv_ray_dir,
    input  logic [2:0]        i_div_by_zero,
    input  logic [IDX_W:0]    i_box_count,
    input  logic              i_mem_stall,
    output logic              o_box_rd_en,
    output logic [IDX_W-1:0]  o_box_rd_addr,
    input  bbox               i_box_rd_data,
    output logic              o_dp_stall,
    output vec3               o_dp_ray_orig,
    output vec3_18_18         o_dp_inv_ray_dir,
    output logic [2:0]        o_dp_div_by_zero,
    output bbox               o_dp_box,
    input  logic              i_dp_hit,
    input  logic [DIST_W-1:0] i_dp_dist,
    output logic              o_res_valid,
    input  logic              i_res_ready,
    output logic              o_res_hit,
    output logic [IDX_W-1:0]  o_res_idx,
    output logic [DIST_W-1:0] o_res_dist
);

    localparam int CNT_W = IDX_W + 1;
    localparam int TAG_W = IDX_W + 1;
    localparam int FLT_W = $clog2(DP_LAT + 2) + 1;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1'b1);
    localparam logic [FLT_W-1:0] FLT_ONE  = FLT_W'(1'b1);
    localparam logic [FLT_W-1:0] FLT_ZERO = {FLT_W{1'b0}};

    scan_state_e       r_state;
    scan_state_e       w_next_state;
    vec3               r_ray_orig;
    vec3_18_18         r_inv_dir;
    logic [2:0]        r_dbz;
    logic [CNT_W-1:0]  r_box_count;
    logic [CNT_W-1:0]  r_issue_cnt;
    logic [FLT_W-1:0]  r_inflight;
    logic              r_best_hit;
    logic [IDX_W-1:0]  r_best_idx;
    logic [DIST_W-1:0] r_best_dist;

    logic              w_accept;
    logic              w_issue;
    logic              w_last_issue;
    logic              w_consume;
    logic              w_take;
    logic [TAG_W-1:0]  w_tag_in;
    logic [TAG_W-1:0]  w_tag_out;

    assign w_accept     = i_ray_valid && (r_state == IDLE);
    assign w_issue      = (r_state == ISSUE) && !i_mem_stall;
    assign w_last_issue = w_issue && ((r_issue_cnt + CNT_ONE) == r_box_count);

    assign o_dp_stall   = i_mem_stall || (r_state == IDLE) || (r_state == DONE);
    assign w_tag_in     = {w_issue, r_issue_cnt[IDX_W-1:0]};
    assign w_consume    = w_tag_out[TAG_W-1] && !o_dp_stall;
    assign w_take       = w_consume && i_dp_hit &&
                          closer_hit(r_best_hit, i_dp_dist, r_best_dist);

    // Valid/index tag rides alongside the memory read and the datapath.
    stall_shift_reg #(
        .WIDTH (TAG_W),
        .DEPTH (1 + DP_LAT)
    ) u_tag_line (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_stall (o_dp_stall),
        .i_din   (w_tag_in),
        .o_dout  (w_tag_out)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state and handshake decode.
    always_comb begin
        w_next_state = r_state;
        o_ray_ready  = 1'b0;
        o_box_rd_en  = 1'b0;
        case (r_state)
            IDLE: begin
                o_ray_ready = 1'b1;
                if (i_ray_valid) begin
                    if (i_box_count == {CNT_W{1'b0}}) begin
                        w_next_state = DONE;
                    end else begin
                        w_next_state = ISSUE;
                    end
                end else begin
                    w_next_state = IDLE;
                end
            end
            ISSUE: begin
                o_box_rd_en = !i_mem_stall;
                if (w_last_issue) begin
                    w_next_state = DRAIN;
                end else begin
                    w_next_state = ISSUE;
                end
            end
            DRAIN: begin
                if ((r_inflight == FLT_ZERO) || (w_consume && (r_inflight == FLT_ONE))) begin
                    w_next_state = DONE;
                end else begin
                    w_next_state = DRAIN;
                end
            end
            DONE: begin
                if (i_res_ready) begin
                    w_next_state = IDLE;
                end else begin
                    w_next_state = DONE;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Ray payload held steady for the datapath for the whole scan.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ray_orig  <= vec3_default;
            r_inv_dir   <= '{x: 36'sd0, y: 36'sd0, z: 36'sd0};
            r_dbz       <= 3'b000;
            r_box_count <= {CNT_W{1'b0}};
        end else if (w_accept) begin
            r_ray_orig  <= i_ray_orig;
            r_inv_dir   <= i_inv_ray_dir;
            r_dbz       <= i_div_by_zero;
            r_box_count <= i_box_count;
        end
    end

    // Read address counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_issue_cnt <= {CNT_W{1'b0}};
        end else if (w_accept) begin
            r_issue_cnt <= {CNT_W{1'b0}};
        end else if (w_issue) begin
            r_issue_cnt <= r_issue_cnt + CNT_ONE;
        end
    end

    // Outstanding tags: issued but not yet consumed at the datapath output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_inflight <= FLT_ZERO;
        end else begin
            case ({w_issue, w_consume})
                2'b10:   r_inflight <= r_inflight + FLT_ONE;
                2'b01:   r_inflight <= r_inflight - FLT_ONE;
                default: r_inflight <= r_inflight;
            endcase
        end
    end

    // Best-hit tracking, cleared when a new ray is accepted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_best_hit  <= 1'b0;
            r_best_idx  <= {IDX_W{1'b0}};
            r_best_dist <= NO_HIT_DIST;
        end else if (w_accept) begin
            r_best_hit  <= 1'b0;
            r_best_idx  <= {IDX_W{1'b0}};
            r_best_dist <= NO_HIT_DIST;
        end else if (w_take) begin
            r_best_hit  <= 1'b1;
            r_best_idx  <= w_tag_out[IDX_W-1:0];
            r_best_dist <= i_dp_dist;
        end
    end

    assign o_box_rd_addr    = r_issue_cnt[IDX_W-1:0];
    assign o_dp_ray_orig    = r_ray_orig;
    assign o_dp_inv_ray_dir = r_inv_dir;
    assign o_dp_div_by_zero = r_dbz;
    assign o_dp_box         = i_box_rd_data;
    assign o_res_valid      = (r_state == DONE);
    assign o_res_hit        = r_best_hit;
    assign o_res_idx        = r_best_idx;
    assign o_res_dist       = r_best_dist;

endmodule

// File: tb/tb_bbox_scan_ctrl.sv
// Bench for bbox_scan_ctrl with a behavioural slab-test datapath and a
// one-cycle box RAM; results are compared to a per-ray closest-hit model.
module tb_bbox_scan_ctrl;
    import bbox_scan_ctrl_pkg::*;

    localparam int IDX_W  = 8;
    localparam int DP_LAT = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              i_ray_valid;
    logic              o_ray_ready;
    vec3               i_ray_orig;
    vec3_18_18         i_inv_ray_dir;
    logic [2:0]        i_div_by_zero;
    logic [IDX_W:0]    i_box_count;
    logic              mem_stall;
    logic              o_box_rd_en;
    logic [IDX_W-1:0]  o_box_rd_addr;
    bbox               box_rd_data;
    logic              o_dp_stall;
    vec3               o_dp_ray_orig;
    vec3_18_18         o_dp_inv_ray_dir;
    logic [2:0]        o_dp_div_by_zero;
    bbox               o_dp_box;
    logic              dp_hit;
    logic [DIST_W-1:0] dp_dist;
    logic              o_res_valid;
    logic              i_res_ready;
    logic              o_res_hit;
    logic [IDX_W-1:0]  o_res_idx;
    logic [DIST_W-1:0] o_res_dist;

    int cyc = 0;
    int rd_pulses = 0;
    int stall_mode = 0;
    int errors = 0;
    int checks = 0;

    bbox        mem [256];
    logic [49:0] dp_pipe [DP_LAT];
    vec3        ray_o;
    vec3_18_18  ray_inv;
    logic [2:0] ray_dbz;

    always #5 clk = ~clk;

    bbox_scan_ctrl #(.IDX_W(IDX_W), .DP_LAT(DP_LAT)) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .i_ray_valid      (i_ray_valid),
        .o_ray_ready      (o_ray_ready),
        .i_ray_orig       (i_ray_orig),
        .i_inv_ray_dir    (i_inv_ray_dir),
        .i_div_by_zero    (i_div_by_zero),
        .i_box_count      (i_box_count),
        .i_mem_stall      (mem_stall),
        .o_box_rd_en      (o_box_rd_en),
        .o_box_rd_addr    (o_box_rd_addr),
        .i_box_rd_data    (box_rd_data),
        .o_dp_stall       (o_dp_stall),
        .o_dp_ray_orig    (o_dp_ray_orig),
        .o_dp_inv_ray_dir (o_dp_inv_ray_dir),
        .o_dp_div_by_zero (o_dp_div_by_zero),
        .o_dp_box         (o_dp_box),
        .i_dp_hit         (dp_hit),
        .i_dp_dist        (dp_dist),
        .o_res_valid      (o_res_valid),
        .i_res_ready      (i_res_ready),
        .o_res_hit        (o_res_hit),
        .o_res_idx        (o_res_idx),
        .o_res_dist       (o_res_dist)
    );

    // Slab test; returns {hit, distance} with distance in 18-bit-fraction units.
    function automatic logic [49:0] isect(input bbox b, input vec3 o,
                                          input vec3_18_18 inv, input logic [2:0] dbz);
        longint lo [3];
        longint hi [3];
        longint og [3];
        longint iv [3];
        longint tn, tf, t1, t2, tmp;
        logic ok;
        lo[0] = $signed(b.lo.x); lo[1] = $signed(b.lo.y); lo[2] = $signed(b.lo.z);
        hi[0] = $signed(b.hi.x); hi[1] = $signed(b.hi.y); hi[2] = $signed(b.hi.z);
        og[0] = $signed(o.x);    og[1] = $signed(o.y);    og[2] = $signed(o.z);
        iv[0] = $signed(inv.x);  iv[1] = $signed(inv.y);  iv[2] = $signed(inv.z);
        tn = -(64'sd1 <<< 62);
        tf = 64'sd1 <<< 62;
        ok = 1'b1;
        for (int a = 0; a < 3; a++) begin
            if (dbz[a]) begin
                if (og[a] < lo[a] || og[a] > hi[a]) ok = 1'b0;
            end else begin
                t1 = (lo[a] - og[a]) * iv[a];
                t2 = (hi[a] - og[a]) * iv[a];
                if (t1 > t2) begin tmp = t1; t1 = t2; t2 = tmp; end
                if (t1 > tn) tn = t1;
                if (t2 < tf) tf = t2;
            end
        end
        if (tn > tf || tf < 0) ok = 1'b0;
        if (tn < 0 || !ok) tn = 0;
        return {ok, tn[48:0]};
    endfunction

    // Closest hit over boxes 0..n-1: {hit, idx, dist}.
    function automatic logic [57:0] ref_scan(input int n);
        logic        bh;
        logic [7:0]  bi;
        logic [48:0] bd;
        logic [49:0] r;
        bh = 1'b0; bi = 8'd0; bd = NO_HIT_DIST;
        for (int i = 0; i < n; i++) begin
            r = isect(mem[i], ray_o, ray_inv, ray_dbz);
            if (r[49] && (!bh || r[48:0] < bd)) begin
                bh = 1'b1; bi = 8'(i); bd = r[48:0];
            end
        end
        return {bh, bi, bd};
    endfunction

    function automatic bbox mk_box(input int lx, input int hx, input int ly,
                                   input int hy, input int lz, input int hz);
        bbox b;
        b.lo.x = 16'(lx); b.hi.x = 16'(hx);
        b.lo.y = 16'(ly); b.hi.y = 16'(hy);
        b.lo.z = 16'(lz); b.hi.z = 16'(hz);
        return b;
    endfunction

    function automatic bbox rnd_box();
        int l0, l1, l2;
        l0 = int'($urandom_range(80)) - 40;
        l1 = int'($urandom_range(80)) - 40;
        l2 = int'($urandom_range(80)) - 40;
        return mk_box(l0, l0 + 5 + int'($urandom_range(40)),
                      l1, l1 + 5 + int'($urandom_range(40)),
                      l2, l2 + 5 + int'($urandom_range(40)));
    endfunction

    function automatic logic [35:0] rnd_inv();
        int v;
        v = int'($urandom_range(32'd524288, 32'd65536));
        if ($urandom_range(1) == 0) v = -v;
        return 36'(v);
    endfunction

    // Behavioural intersection datapath: DP_LAT stages, frozen by dp_stall.
    always @(posedge clk) begin
        if (!o_dp_stall) begin
            dp_pipe[0] <= isect(o_dp_box, o_dp_ray_orig, o_dp_inv_ray_dir, o_dp_div_by_zero);
            for (int i = 1; i < DP_LAT; i++) dp_pipe[i] <= dp_pipe[i-1];
        end
    end
    assign dp_hit  = dp_pipe[DP_LAT-1][49];
    assign dp_dist = dp_pipe[DP_LAT-1][48:0];

    // Box RAM with one cycle read latency.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (o_box_rd_en) begin
            box_rd_data <= mem[o_box_rd_addr];
            rd_pulses   <= rd_pulses + 1;
        end
    end

    initial begin
        mem_stall = 1'b0;
        forever begin
            @(negedge clk);
            case (stall_mode)
                1:       mem_stall = (cyc % 3 == 2);
                2:       mem_stall = ($urandom_range(3) == 0);
                default: mem_stall = 1'b0;
            endcase
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Send one ray, wait for the result (bounded), optionally release it.
    task automatic run_scan(input int cnt, input logic release_res,
                            output logic h, output logic [7:0] idx,
                            output logic [48:0] d, output int lat);
        int  start;
        logic timed_out, ready_low, payload_ok;
        @(negedge clk);
        check("ready_before_ray", o_ray_ready, 1'b1);
        i_ray_valid   = 1'b1;
        i_ray_orig    = ray_o;
        i_inv_ray_dir = ray_inv;
        i_div_by_zero = ray_dbz;
        i_box_count   = 9'(cnt);
        start = cyc;
        @(negedge clk);
        i_ray_valid = 1'b0;
        timed_out = 1'b1; ready_low = 1'b1; payload_ok = 1'b1;
        for (int k = 0; k < 3000; k++) begin
            if (o_res_valid) begin timed_out = 1'b0; break; end
            if (o_ray_ready !== 1'b0) ready_low = 1'b0;
            if (o_dp_ray_orig !== ray_o || o_dp_inv_ray_dir !== ray_inv ||
                o_dp_div_by_zero !== ray_dbz) payload_ok = 1'b0;
            @(negedge clk);
        end
        lat = cyc - start;
        h = o_res_hit; idx = o_res_idx; d = o_res_dist;
        check("result_timeout", timed_out, 1'b0);
        check("ready_low_in_flight", ready_low, 1'b1);
        check("dp_payload_stable", payload_ok, 1'b1);
        if (release_res) begin
            i_res_ready = 1'b1;
            @(negedge clk);
            i_res_ready = 1'b0;
        end
    endtask

    initial begin
        bbox behind, in_front, above;
        logic h, h2;
        logic [7:0] idx, idx2;
        logic [48:0] d, d2;
        logic [57:0] exp_r;
        logic [59:0] snap;
        int lat, lat2, p0, n;
        logic seen;

        i_ray_valid = 1'b0; i_res_ready = 1'b0; i_box_count = 9'd0;
        i_ray_orig = vec3_default; i_inv_ray_dir = '{x: 36'sd0, y: 36'sd0, z: 36'sd0};
        i_div_by_zero = 3'b000;
        behind   = mk_box(-20, -10, -5, 5, -5, 5);
        in_front = mk_box(10, 20, -5, 5, -5, 5);
        above    = mk_box(10, 20, 10, 20, -5, 5);
        for (int i = 0; i < 256; i++) mem[i] = behind;

        repeat (3) @(negedge clk);
        check("rst_ray_ready", o_ray_ready, 1'b1);
        check("rst_res_valid", o_res_valid, 1'b0);
        check("rst_rd_en", o_box_rd_en, 1'b0);
        check("rst_res_hit", o_res_hit, 1'b0);
        check("rst_res_idx", o_res_idx, 8'd0);
        check("rst_res_dist", o_res_dist, NO_HIT_DIST);
        check("rst_ray_regs", {o_dp_ray_orig, o_dp_inv_ray_dir, o_dp_div_by_zero}, 64'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_release", o_ray_ready, 1'b1);

        // Ray along +x from the origin; y and z are parallel axes.
        ray_o = vec3_default;
        ray_inv = '{x: 36'sd262144, y: 36'sd0, z: 36'sd0};
        ray_dbz = 3'b110;
        mem[0] = behind; mem[1] = in_front; mem[2] = above;
        run_scan(3, 1'b1, h, idx, d, lat);
        check("hit3_hit", h, 1'b1);
        check("hit3_idx", idx, 8'd1);
        check("hit3_dist", d, 49'd2621440);
        check("hit3_latency", lat, 3 + DP_LAT + 2);

        mem[0] = behind; mem[1] = above;
        run_scan(2, 1'b1, h, idx, d, lat);
        check("miss2_hit", h, 1'b0);
        check("miss2_idx", idx, 8'd0);
        check("miss2_dist", d, NO_HIT_DIST);

        p0 = rd_pulses;
        run_scan(0, 1'b1, h, idx, d, lat);
        check("zero_lat_le2", (lat <= 2), 1'b1);
        check("zero_no_reads", rd_pulses - p0, 0);
        check("zero_hit", h, 1'b0);
        check("zero_dist", d, NO_HIT_DIST);

        // Equal in_front boxes at 3 and 5: unstalled then with periodic stalls.
        for (int i = 0; i < 8; i++) mem[i] = (i % 2 == 0) ? behind : above;
        mem[3] = in_front; mem[5] = in_front;
        run_scan(8, 1'b1, h, idx, d, lat);
        stall_mode = 1;
        run_scan(8, 1'b1, h2, idx2, d2, lat2);
        stall_mode = 0;
        check("tie_idx", idx, 8'd3);
        check("tie_dist", d, 49'd2621440);
        check("stall_idx", idx2, 8'd3);
        check("stall_same", {h2, idx2, d2}, {h, idx, d});

        // Result held while res_ready stays low.
        mem[0] = behind; mem[1] = in_front; mem[2] = above;
        run_scan(3, 1'b0, h, idx, d, lat);
        snap = {1'b1, h, idx, d, 1'b0};
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("hold_stable", {o_res_valid, o_res_hit, o_res_idx, o_res_dist, o_ray_ready}, snap);
        end
        i_res_ready = 1'b1;
        @(negedge clk);
        i_res_ready = 1'b0;
        check("hold_released", o_res_valid, 1'b0);

        // Randomized rays against the closest-hit model.
        for (int r = 0; r < 16; r++) begin
            n = int'($urandom_range(40, 1));
            for (int i = 0; i < n; i++) mem[i] = rnd_box();
            ray_o.x = 16'(int'($urandom_range(20)) - 10);
            ray_o.y = 16'(int'($urandom_range(20)) - 10);
            ray_o.z = 16'(int'($urandom_range(20)) - 10);
            ray_inv.x = rnd_inv(); ray_inv.y = rnd_inv(); ray_inv.z = rnd_inv();
            ray_dbz = {($urandom_range(3) == 0), ($urandom_range(3) == 0), ($urandom_range(3) == 0)};
            stall_mode = int'($urandom_range(2));
            exp_r = ref_scan(n);
            run_scan(n, 1'b1, h, idx, d, lat);
            check("rand_result", {h, idx, d}, exp_r);
            if (stall_mode == 0) check("rand_latency", lat, n + DP_LAT + 2);
        end
        stall_mode = 0;

        // Reset in the middle of a long scan.
        ray_o = vec3_default;
        ray_inv = '{x: 36'sd262144, y: 36'sd0, z: 36'sd0};
        ray_dbz = 3'b110;
        @(negedge clk);
        @(negedge clk);
        i_ray_valid = 1'b1; i_ray_orig = ray_o; i_inv_ray_dir = ray_inv;
        i_div_by_zero = ray_dbz; i_box_count = 9'd200;
        @(negedge clk);
        i_ray_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("mid_issue_rd_en", o_box_rd_en, 1'b1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_rd_en", o_box_rd_en, 1'b0);
        check("mid_rst_dist", o_res_dist, NO_HIT_DIST);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_ready", o_ray_ready, 1'b1);
        seen = 1'b0;
        for (int k = 0; k < 300; k++) begin
            if (o_res_valid) seen = 1'b1;
            @(negedge clk);
        end
        check("post_rst_no_result", seen, 1'b0);

        mem[0] = behind; mem[1] = in_front; mem[2] = above;
        run_scan(3, 1'b1, h, idx, d, lat);
        check("recover_result", {h, idx, d}, {1'b1, 8'd1, 49'd2621440});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/bbox_scan_ctrl.md
BBOX_SCAN_CTRL -- requirements
Module: bbox_scan_ctrl

Interface
REQ-001 SHALL have parameters: IDX_W, default 8, box index width (up to 256 boxes); DP_LAT, default 4, ray_bbox_intersect cycles from box input to hit/closest_hit_distance output.
REQ-002 SHALL have ports: clk in 1, single clock; rst_n in 1, asynchronous active-low reset.
REQ-003 ray_valid in 1 / ray_ready out 1: ray request handshake; transfer occurs when both are high on a rising clk edge.
REQ-004 ray_orig in vec3, inv_ray_dir in vec3_18_18, div_by_zero in 3, box_count in IDX_W+1: ray request payload, where box_count is the number of boxes to scan (0..2^IDX_W).
REQ-005 mem_stall in 1: box memory not ready; freezes issue, the tag pipeline and the datapath.
REQ-006 box_rd_en out 1, box_rd_addr out IDX_W, box_rd_data in bbox: box memory port; read data is valid exactly 1 cycle after an unstalled box_rd_en.
REQ-007 dp_stall out 1, dp_ray_orig out vec3, dp_inv_ray_dir out vec3_18_18, dp_div_by_zero out 3, dp_box out bbox, dp_hit in 1, dp_dist in 49: ray_bbox_intersect drive and return signals.
REQ-008 res_valid out 1, res_ready in 1, res_hit out 1, res_idx out IDX_W, res_dist out 49: result handshake and payload.

Function
REQ-009 States SHALL be IDLE, ISSUE, DRAIN and DONE.
REQ-010 IDLE: ray_ready=1; on ray transfer, latch the payload into registers that drive dp_ray_orig/dp_inv_ray_dir/dp_div_by_zero unchanged until return to IDLE; go to ISSUE, or to DONE if box_count==0.
REQ-011 ISSUE: each cycle with mem_stall=0, assert box_rd_en with addr = 0,1,...,box_count-1 in order; after the last address go to DRAIN; with mem_stall=1, box_rd_en=0 and the address holds.
REQ-012 dp_box SHALL be box_rd_data; a valid bit and index tag SHALL travel 1+DP_LAT stages alongside, advancing only when dp_stall=0.
REQ-013 dp_stall SHALL equal mem_stall OR (state==IDLE) OR (state==DONE).
REQ-014 On each emerging valid tag with dp_hit=1: if no hit is held, or dp_dist < best_dist (unsigned compare), capture hit=1, idx=tag, dist=dp_dist; equal distance keeps the earlier (lower) index.
REQ-015 DRAIN: go to DONE in the cycle after the last valid tag emerges; an in-flight counter (0..1+DP_LAT) SHALL track outstanding tags.
REQ-016 DONE: res_valid=1 with a stable payload until res_ready=1, then go to IDLE; best registers SHALL be re-initialised on the next ray accept.
REQ-017 No hit, including box_count==0: res_hit=0, res_idx=0, res_dist=all ones.
REQ-018 ray_ready SHALL be 0 in every state except IDLE; a second ray is never accepted while one is in flight.
REQ-019 Throughput: one box per unstalled cycle; with no stalls, res_valid rises box_count+DP_LAT+2 cycles after ray transfer (box_count>=1).

Reset
REQ-020 rst_n low SHALL asynchronously force: state=IDLE, all tag valids=0, in-flight=0, box_rd_en=0, res_valid=0, res_hit=0, res_idx=0, res_dist=all ones, ray registers=0; ray_ready=1 after release.
REQ-021 Reset mid-scan SHALL discard all in-flight work with no result emitted.

Structure
REQ-022 vec3, vec3_18_18, bbox and vec3_default SHALL come from the shared data_macros definitions; the no-hit distance constant and the state enum SHALL be added there.
REQ-023 The tag delay line SHALL be a sub-module named stall_shift_reg (parameters WIDTH, DEPTH, with a stall input); ray_bbox_intersect SHALL be instantiated outside this block.

Verification
REQ-024 Bench SHALL pair the block with the real ray_bbox_intersect and a 1-cycle box RAM.
REQ-025 Origin (vec3_default) ray, inv_dir x=1<<18, y=z=0, div_by_zero=3'b110; boxes {behind, in_front, above}, box_count=3 -> res_hit=1, res_idx=1, res_dist equal to the datapath distance for in_front.
REQ-026 Same ray with boxes {behind, above}, box_count=2 -> res_hit=0, res_idx=0, res_dist=all ones.
REQ-027 box_count=0 -> res_valid within 2 cycles of accept, no box_rd_en pulses, res_hit=0.
REQ-028 Two identical in_front boxes at idx 3 and 5 among misses, with mem_stall toggled every 3rd cycle -> res_idx=3, result identical to the unstalled run.
REQ-029 res_ready held low 10 cycles -> res_valid and payload stable, ray_ready=0 throughout; rst_n pulsed mid-ISSUE -> no res_valid, ray_ready=1 after release.
